// File: rtl/pattern_bist_ctrl.sv
// rtl/pattern_bist_ctrl.sv - LFSR stimulus generator with MISR response compaction
// Launches N_PATTERNS LFSR patterns and folds the delayed responses into a 16-bit signature.
module pattern_bist_ctrl #(
  parameter int         N_PATTERNS = 32,
  parameter int         PIPE_LAT   = 3,
  parameter logic [4:0] SEED       = 5'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  pat_out,
  input  logic [1:0]  dut_resp,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        sig_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [4:0] LP_SEED = (SEED == 5'h00) ? 5'h01 : SEED;
  localparam logic [7:0] LP_N    = 8'(N_PATTERNS);
  localparam logic [7:0] LP_LAST = 8'(N_PATTERNS - 1);

  logic [1:0]          r_state;
  logic [4:0]          r_lfsr;
  logic [15:0]         r_misr;
  logic [7:0]          r_launch_cnt;
  logic [7:0]          r_cap_cnt;
  logic [PIPE_LAT-1:0] r_vpipe;
  logic [4:0]          r_pat;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_sig;
  logic                r_sig_valid;

  logic [4:0]          w_lfsr_next;
  logic                w_accept;
  logic                w_launch;
  logic                w_capture;
  logic                w_last_cap;
  logic [15:0]         w_misr_next;
  logic [PIPE_LAT:0]   w_vshift;

  assign w_lfsr_next = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_launch    = w_accept || ((r_state == ST_DRIVE) && (r_launch_cnt != LP_N));
  // Bit PIPE_LAT-1 set means the pattern launched PIPE_LAT edges ago is answering now.
  assign w_vshift    = {r_vpipe, w_launch};
  assign w_capture   = r_vpipe[PIPE_LAT-1];
  assign w_last_cap  = w_capture && (r_cap_cnt == LP_LAST);
  assign w_misr_next = ({r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000))
                       ^ {14'b0, dut_resp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= LP_SEED;
      r_misr       <= 16'h0000;
      r_launch_cnt <= 8'd0;
      r_cap_cnt    <= 8'd0;
      r_vpipe      <= '0;
      r_pat        <= 5'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sig        <= 16'h0000;
      r_sig_valid  <= 1'b0;
    end else begin
      r_vpipe <= w_vshift[PIPE_LAT-1:0];
      r_done  <= 1'b0;
      if (w_capture) begin
        r_misr    <= w_misr_next;
        r_cap_cnt <= r_cap_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_lfsr       <= LP_SEED;
            r_pat        <= LP_SEED;
            r_launch_cnt <= 8'd1;
            r_cap_cnt    <= 8'd0;
            r_misr       <= 16'h0000;
            r_sig_valid  <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_DRIVE;
          end
        end
        ST_DRIVE, ST_DRAIN: begin
          if (r_state == ST_DRIVE) begin
            if (r_launch_cnt != LP_N) begin
              r_lfsr       <= w_lfsr_next;
              r_pat        <= w_lfsr_next;
              r_launch_cnt <= r_launch_cnt + 8'd1;
            end else begin
              r_pat   <= 5'h00;
              r_state <= ST_DRAIN;
            end
          end
          // With PIPE_LAT=1 the last capture lands on the DRIVE exit edge and wins over DRAIN.
          if (w_last_cap) begin
            r_pat       <= 5'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_sig       <= w_misr_next;
            r_sig_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pat_out   = r_pat;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign sig_valid = r_sig_valid;

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// tb/tb_pattern_bist_ctrl.sv - scoreboard bench for pattern_bist_ctrl over five parameter sets
module tb_pattern_bist_ctrl;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NI];
  logic        start [NI];
  logic [1:0]  resp  [NI];
  logic [4:0]  pat   [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic [15:0] sig   [NI];
  logic        sv    [NI];

  logic [4:0]  exp_pat_q [NI][$];
  logic [15:0] exp_sig_q [NI][$];
  logic [4:0]  lfsr_seq [31];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0: SEED=1 N=6 P=3   1: SEED=1 N=2 P=3   2: SEED=1 N=32 P=3   3: SEED=0 N=4 P=3   4: SEED=0A N=3 P=1
  pattern_bist_ctrl #(.N_PATTERNS(6), .PIPE_LAT(3), .SEED(5'h01)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .pat_out(pat[0]), .dut_resp(resp[0]),
    .busy(busy[0]), .done(done[0]), .signature(sig[0]), .sig_valid(sv[0]));
  pattern_bist_ctrl #(.N_PATTERNS(2), .PIPE_LAT(3), .SEED(5'h01)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .pat_out(pat[1]), .dut_resp(resp[1]),
    .busy(busy[1]), .done(done[1]), .signature(sig[1]), .sig_valid(sv[1]));
  pattern_bist_ctrl #(.N_PATTERNS(32), .PIPE_LAT(3), .SEED(5'h01)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .pat_out(pat[2]), .dut_resp(resp[2]),
    .busy(busy[2]), .done(done[2]), .signature(sig[2]), .sig_valid(sv[2]));
  pattern_bist_ctrl #(.N_PATTERNS(4), .PIPE_LAT(3), .SEED(5'h00)) u_dut3 (
    .clk(clk), .rst_n(rst_n[3]), .start(start[3]), .pat_out(pat[3]), .dut_resp(resp[3]),
    .busy(busy[3]), .done(done[3]), .signature(sig[3]), .sig_valid(sv[3]));
  pattern_bist_ctrl #(.N_PATTERNS(3), .PIPE_LAT(1), .SEED(5'h0A)) u_dut4 (
    .clk(clk), .rst_n(rst_n[4]), .start(start[4]), .pat_out(pat[4]), .dut_resp(resp[4]),
    .busy(busy[4]), .done(done[4]), .signature(sig[4]), .sig_valid(sv[4]));

  for (genvar g = 0; g < NI; g++) begin : g_mon
    always @(negedge clk) begin
      if (busy[g] === 1'b1) begin
        if (exp_pat_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pat%0d: unexpected busy cycle, pat_out=%0h expected idle", g, pat[g]);
        end else begin
          chk($sformatf("pat%0d", g), 32'(pat[g]), 32'(exp_pat_q[g].pop_front()));
        end
      end
      if (done[g] === 1'b1) begin
        if (exp_sig_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done%0d: unexpected done pulse, signature=%0h expected none", g, sig[g]);
        end else begin
          chk($sformatf("sig%0d", g), 32'(sig[g]), 32'(exp_sig_q[g].pop_front()));
          chk($sformatf("sig_valid_at_done%0d", g), 32'(sv[g]), 32'd1);
        end
      end
    end
  end

  initial begin
    lfsr_seq = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C, 5'h19,
                 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06,
                 5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D, 5'h1A, 5'h15, 5'h0A, 5'h14, 5'h08, 5'h10};
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1;
      start[i] = 1'b0;
      resp[i]  = 2'b00;
    end
    #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_pat%0d", i),  32'(pat[i]),  32'h0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'h0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'h0);
      chk($sformatf("rst_sig%0d", i),  32'(sig[i]),  32'h0);
      chk($sformatf("rst_sv%0d", i),   32'(sv[i]),   32'h0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Instance 0: pattern order, resp=3 -> 0x0041, mid-run start ignored
    for (int k = 0; k < 6; k++) exp_pat_q[0].push_back(lfsr_seq[k]);
    exp_pat_q[0].push_back(5'h00);
    exp_pat_q[0].push_back(5'h00);
    exp_sig_q[0].push_back(16'h0041);
    resp[0] = 2'b11;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy0", 32'(busy[0]), 32'h0);
    chk("hold_sv0", 32'(sv[0]), 32'h1);
    chk("hold_sig0", 32'(sig[0]), 32'h0041);

    // Instance 1: done one cycle after E4, signature 0x0003 held
    exp_pat_q[1].push_back(5'h01);
    exp_pat_q[1].push_back(5'h02);
    exp_pat_q[1].push_back(5'h00);
    exp_pat_q[1].push_back(5'h00);
    exp_sig_q[1].push_back(16'h0003);
    resp[1] = 2'b01;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_early1", 32'(done[1]), 32'h0);
    @(negedge clk);
    chk("done_e4_1", 32'(done[1]), 32'h1);
    repeat (3) @(negedge clk);
    chk("done_pulse1", 32'(done[1]), 32'h0);
    chk("hold_sv1", 32'(sv[1]), 32'h1);
    chk("hold_sig1", 32'(sig[1]), 32'h0003);

    // Instance 2: start held high, two 32-pattern runs back-to-back
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 32; k++) exp_pat_q[2].push_back(lfsr_seq[k % 31]);
      exp_pat_q[2].push_back(5'h00);
      exp_pat_q[2].push_back(5'h00);
    end
    exp_sig_q[2].push_back(16'h0000);
    exp_sig_q[2].push_back(16'hE2F0);
    resp[2] = 2'b00;
    start[2] = 1'b1;
    @(negedge clk);
    repeat (34) @(negedge clk);
    chk("done_run1_2", 32'(done[2]), 32'h1);
    @(negedge clk);
    chk("gap_busy2", 32'(busy[2]), 32'h0);
    chk("gap_done2", 32'(done[2]), 32'h0);
    chk("gap_sv2", 32'(sv[2]), 32'h1);
    resp[2] = 2'b01;
    @(negedge clk);
    chk("rerun_busy2", 32'(busy[2]), 32'h1);
    chk("rerun_sv_clear2", 32'(sv[2]), 32'h0);
    start[2] = 1'b0;
    repeat (37) @(negedge clk);
    chk("hold_sv2", 32'(sv[2]), 32'h1);
    chk("hold_sig2", 32'(sig[2]), 32'hE2F0);

    // Instance 3: SEED=0, reset during DRAIN, then a fresh run
    exp_pat_q[3].push_back(5'h01);
    exp_pat_q[3].push_back(5'h02);
    exp_pat_q[3].push_back(5'h04);
    exp_pat_q[3].push_back(5'h09);
    resp[3] = 2'b10;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_pat3", 32'(pat[3]), 32'h0);
    chk("drain_busy3", 32'(busy[3]), 32'h1);
    #1;
    rst_n[3] = 1'b0;
    #1;
    chk("abort_pat3", 32'(pat[3]), 32'h0);
    chk("abort_busy3", 32'(busy[3]), 32'h0);
    chk("abort_done3", 32'(done[3]), 32'h0);
    chk("abort_sig3", 32'(sig[3]), 32'h0);
    chk("abort_sv3", 32'(sv[3]), 32'h0);
    repeat (3) @(negedge clk);
    rst_n[3] = 1'b1;
    repeat (4) @(negedge clk);
    chk("wait_start_busy3", 32'(busy[3]), 32'h0);
    exp_pat_q[3].push_back(5'h01);
    exp_pat_q[3].push_back(5'h02);
    exp_pat_q[3].push_back(5'h04);
    exp_pat_q[3].push_back(5'h09);
    exp_pat_q[3].push_back(5'h00);
    exp_pat_q[3].push_back(5'h00);
    exp_sig_q[3].push_back(16'h001E);
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    repeat (10) @(negedge clk);

    // Instance 4: PIPE_LAT=1 skips DRAIN; resp on non-capture edges must not matter
    exp_pat_q[4].push_back(5'h0A);
    exp_pat_q[4].push_back(5'h14);
    exp_pat_q[4].push_back(5'h08);
    exp_sig_q[4].push_back(16'h0009);
    resp[4] = 2'b11;
    start[4] = 1'b1;
    @(negedge clk);
    start[4] = 1'b0;
    resp[4] = 2'b10;
    @(negedge clk);
    resp[4] = 2'b01;
    @(negedge clk);
    resp[4] = 2'b11;
    @(negedge clk);
    chk("done_p1_4", 32'(done[4]), 32'h1);
    chk("busy_p1_4", 32'(busy[4]), 32'h0);
    resp[4] = 2'b10;
    repeat (4) @(negedge clk);
    chk("hold_sig4", 32'(sig[4]), 32'h0009);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("pat_left%0d", i), 32'(exp_pat_q[i].size()), 32'd0);
      chk($sformatf("sig_left%0d", i), 32'(exp_sig_q[i].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_bist_ctrl.md
PATTERN_BIST_CTRL -- requirements
Module: pattern_bist_ctrl

Interface
REQ-001 The block SHALL have parameter N_PATTERNS, default 32, giving patterns per run (legal range 1..255).
REQ-002 The block SHALL have parameter PIPE_LAT, default 3, giving clock edges from pattern launch to response capture (legal range 1..8).
REQ-003 The block SHALL have parameter SEED, default 5'h01, giving the LFSR start value.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state rising-edge triggered.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 The block SHALL have port pat_out, output, 5 bits: stimulus to the circuit under test.
REQ-008 The block SHALL have port dut_resp, input, 2 bits: response from the circuit under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high in DRIVE and DRAIN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port signature, output, 16 bits: compacted response.
REQ-012 The block SHALL have port sig_valid, output, 1 bit: signature holds a completed run's result.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, DRAIN and DONE, and all outputs SHALL be registered.
REQ-014 IDLE, start=1 at edge E0 SHALL: load LFSR with SEED (SEED=0 substituted by 5'h01); clear MISR to 0; clear pattern count; clear sig_valid; enter DRIVE.
REQ-015 In DRIVE, pattern k (k=0..N_PATTERNS-1) SHALL appear on pat_out from edge E(k) through E(k+1).
REQ-016 Each DRIVE edge SHALL advance the LFSR as next = {l[3:0], l[4]^l[2]} (x^5+x^3+1, period 31); patterns repeat after 31.
REQ-017 After N_PATTERNS patterns have been launched, the FSM SHALL enter DRAIN and SHALL drive pat_out = 0.
REQ-018 A PIPE_LAT-deep valid shift register SHALL tag launches; the response for pattern k SHALL be sampled at edge E(k+PIPE_LAT).
REQ-019 Exactly N_PATTERNS responses SHALL be captured per run.
REQ-020 Each capture SHALL update the MISR as next = ({m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 0)) ^ {14'b0, dut_resp}.
REQ-021 The edge capturing the final response SHALL move the FSM to DONE; when PIPE_LAT=1 this SHALL skip DRAIN.
REQ-022 In DONE (one cycle), done SHALL be 1 and signature SHALL show the final MISR value.
REQ-023 sig_valid SHALL go 1 in DONE and hold until the next accepted start or reset.
REQ-024 The FSM SHALL then return to IDLE.
REQ-025 signature SHALL hold its value in IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 With start held high, runs SHALL go back-to-back with exactly one IDLE cycle between DONE and the next DRIVE.
REQ-028 dut_resp SHALL be ignored on non-capture edges.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force: FSM=IDLE; pat_out=0; busy=0; done=0; sig_valid=0; signature=0; MISR=0; LFSR=SEED; counters and valid pipeline=0.
REQ-030 Reset mid-run SHALL abort the run with no done pulse.
REQ-031 After rst_n rises, the block SHALL wait for a fresh start.

Verification
REQ-032 rst_n low, no clock -> pat_out=0, busy=0, done=0, signature=16'h0000, sig_valid=0.
REQ-033 SEED=1, N_PATTERNS=6, start pulse -> pat_out = 01,02,04,09,12,05 on consecutive cycles, then 00; busy high from E0 until DONE.
REQ-034 N_PATTERNS=2, PIPE_LAT=3, dut_resp held 2'b01 -> done pulses one cycle after edge E4; signature=16'h0003; sig_valid=1 and held.
REQ-035 N_PATTERNS=32, dut_resp tied 0 -> signature=16'h0000; pat_out sequence wraps to 01 at the 32nd pattern.
REQ-036 start pulsed during DRIVE, then start held high -> mid-run pulse has no effect; second run begins one IDLE cycle after DONE; sig_valid clears on acceptance.
REQ-037 rst_n asserted during DRAIN, and SEED=0 -> all outputs zero at once, no done pulse; the SEED=0 run emits 01 as its first pattern.
